// File: rtl/bypass_regfile_pkg.sv
// Shared constants and helpers for the bypassing register file.
// Imported by the tracker top and the per-port match select.
package bypass_regfile_pkg;

  localparam int unsigned REG_ZERO = 0;

  localparam int unsigned ENT_FLAGS_W = 2;

  function automatic int aw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ent_w(
    input int aw,
    input int w
  );
    return aw + w + ENT_FLAGS_W;
  endfunction

endpackage

// File: rtl/bypass_regfile_match.sv
// Per-port priority select over tracker entries and regfile data.
// Youngest matching entry wins; an unready winner raises need_stall.
module bypass_match
  import bypass_regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int AW     = 5,
  parameter int STAGES = 2
) (
  input  logic                         en,
  input  logic [AW-1:0]                addr,
  input  logic [STAGES:0]              ev,
  input  logic [STAGES:0][AW-1:0]      ea,
  input  logic [STAGES:0][WIDTH-1:0]   ed,
  input  logic [STAGES:0]              er,
  input  logic [WIDTH-1:0]             rf,
  output logic [WIDTH-1:0]             data,
  output logic                         need_stall
);

  logic             active;
  logic [WIDTH-1:0] sel_d;
  logic             sel_r;

  assign active = en & (addr != AW'(REG_ZERO));

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    sel_d = rf;
    sel_r = 1'b1;
    for (int i = STAGES; i >= 0; i--) begin
      if (ev[i] && (ea[i] == addr)) begin
        sel_d = ed[i];
        sel_r = er[i];
      end
    end
  end

  always_comb begin
    data       = '0;
    need_stall = 1'b0;
    unique case (1'b1)
      !active: begin
        data       = '0;
        need_stall = 1'b0;
      end
      !sel_r: begin
        data       = '0;
        need_stall = 1'b1;
      end
      default: begin
        data       = sel_d;
        need_stall = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bypass_regfile.sv
// Register file with an EX..WB write tracker and per-port forwarding.
// Loads enter unready and are filled from mem_fill_data leaving T1.
module bypass_regfile
  import bypass_regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NREG   = 32,
  parameter int NREAD  = 2,
  parameter int STAGES = 2,
  localparam int AW    = aw_of(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic                   ex_we,
  input  logic [AW-1:0]          ex_waddr,
  input  logic [WIDTH-1:0]       ex_wdata,
  input  logic                   ex_late,
  input  logic                   ex_flush,
  input  logic [WIDTH-1:0]       mem_fill_data,
  input  logic [NREAD-1:0]       re,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic                   hazard
);

  logic                        t0_v;
  logic                        t0_r;

  logic [STAGES:1]             tv;
  logic [STAGES:1]             tr;
  logic [STAGES:1][AW-1:0]     ta;
  logic [STAGES:1][WIDTH-1:0]  td;

  logic [STAGES:1]             sr;
  logic [STAGES:1][WIDTH-1:0]  sd;
  logic                        fill;
  logic                        commit;

  logic [WIDTH-1:0]            regs [NREG];

  logic [STAGES:0]             me_v;
  logic [STAGES:0]             me_r;
  logic [STAGES:0][AW-1:0]     me_a;
  logic [STAGES:0][WIDTH-1:0]  me_d;

  logic [NREAD-1:0]            stall;

  assign t0_v = ex_we & ~ex_flush
              & (ex_waddr != AW'(REG_ZERO));
  assign t0_r = ~ex_late;

  assign fill   = tv[1] & ~tr[1];
  assign commit = tv[STAGES] & ~hold;

  // Shift view of the tracker with the T1 load already filled.
  always_comb begin
    sd = td;
    sr = tr;
    if (fill) begin
      sd[1] = mem_fill_data;
      sr[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tv <= '0;
      tr <= '0;
      ta <= '0;
      td <= '0;
    end else if (!hold) begin
      tv[1] <= t0_v;
      tr[1] <= t0_r;
      ta[1] <= ex_waddr;
      td[1] <= ex_wdata;
      for (int i = 2; i <= STAGES; i++) begin
        tv[i] <= tv[i-1];
        tr[i] <= sr[i-1];
        ta[i] <= ta[i-1];
        td[i] <= sd[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[ta[STAGES]] <= sd[STAGES];
    end
  end

  assign me_v = {tv, t0_v};
  assign me_r = {tr, t0_r};
  assign me_a = {ta, ex_waddr};
  assign me_d = {td, ex_wdata};

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    logic             st;

    assign a = raddr[k*AW +: AW];

    bypass_match #(
      .WIDTH  (WIDTH),
      .AW     (AW),
      .STAGES (STAGES)
    ) u_match (
      .en         (re[k]),
      .addr       (a),
      .ev         (me_v),
      .ea         (me_a),
      .ed         (me_d),
      .er         (me_r),
      .rf         (regs[a]),
      .data       (d),
      .need_stall (st)
    );

    assign rdata[k*WIDTH +: WIDTH] = rst ? d : '0;
    assign stall[k] = st;
  end

  assign hazard = rst & (|stall);

endmodule

// File: tb/tb_bypass_regfile.sv
// Directed bench for bypass_regfile with a queue-based reference model.
module tb_bypass_regfile;

  localparam int W  = 32;
  localparam int N  = 32;
  localparam int NR = 2;
  localparam int S  = 2;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              hold = 1'b0;
  logic              ex_we = 1'b0;
  logic [AW-1:0]     ex_waddr = '0;
  logic [W-1:0]      ex_wdata = '0;
  logic              ex_late = 1'b0;
  logic              ex_flush = 1'b0;
  logic [W-1:0]      mem_fill_data = '0;
  logic [NR-1:0]     re = '0;
  logic [NR*AW-1:0]  raddr = '0;
  logic [NR*W-1:0]   rdata;
  logic              hazard;

  int tests = 0;
  int fails = 0;

  bypass_regfile #(
    .WIDTH  (W),
    .NREG   (N),
    .NREAD  (NR),
    .STAGES (S)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hold          (hold),
    .ex_we         (ex_we),
    .ex_waddr      (ex_waddr),
    .ex_wdata      (ex_wdata),
    .ex_late       (ex_late),
    .ex_flush      (ex_flush),
    .mem_fill_data (mem_fill_data),
    .re            (re),
    .raddr         (raddr),
    .rdata         (rdata),
    .hazard        (hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    bit            r;
  } ent_t;

  ent_t         pipe[$];
  logic [W-1:0] mregs [N];

  task automatic model_reset();
    ent_t e;
    e.v = 0;
    e.a = '0;
    e.d = '0;
    e.r = 1;
    pipe.delete();
    for (int i = 0; i < S; i++) pipe.push_back(e);
    for (int i = 0; i < N; i++) mregs[i] = '0;
  endtask

  // pipe[0] is the MEM entry, pipe[S-1] the one retiring at WB.
  always @(posedge clk or negedge rst) begin : upd
    ent_t e;
    ent_t t0;
    if (!rst) begin
      model_reset();
    end else if (!hold) begin
      e = pipe[0];
      if (e.v && !e.r) begin
        e.d = mem_fill_data;
        e.r = 1;
        pipe[0] = e;
      end
      e = pipe[S-1];
      if (e.v) mregs[e.a] = e.d;
      t0.v = ex_we && !ex_flush && (ex_waddr != 0);
      t0.a = ex_waddr;
      t0.d = ex_wdata;
      t0.r = !ex_late;
      void'(pipe.pop_back());
      pipe.push_front(t0);
    end
  end

  task automatic exp_port(
    input  int           k,
    output logic [W-1:0] d,
    output bit           h
  );
    logic [AW-1:0] a;
    d = '0;
    h = 0;
    a = raddr[k*AW +: AW];
    if (!rst || !re[k] || a == 0) return;
    if (ex_we && !ex_flush && ex_waddr == a) begin
      if (ex_late) h = 1;
      else d = ex_wdata;
      return;
    end
    foreach (pipe[i]) begin
      if (pipe[i].v && pipe[i].a == a) begin
        if (pipe[i].r) d = pipe[i].d;
        else h = 1;
        return;
      end
    end
    d = mregs[a];
  endtask

  always @(negedge clk) begin : cmp
    logic [W-1:0] d;
    bit           h;
    bit           hx;
    hx = 0;
    for (int k = 0; k < NR; k++) begin
      exp_port(k, d, h);
      hx = hx | h;
      tests++;
      if (rdata[k*W +: W] !== d) begin
        fails++;
        $display("FAIL model_rdata%0d t=%0t: got %h want %h",
                 k, $time, rdata[k*W +: W], d);
      end
    end
    tests++;
    if (hazard !== hx) begin
      fails++;
      $display("FAIL model_hazard t=%0t: got %b want %b",
               $time, hazard, hx);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(
    input string        n,
    input logic [W-1:0] act,
    input logic [W-1:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic ex(
    input logic [AW-1:0] a,
    input logic [W-1:0]  d,
    input bit            late,
    input bit            fl
  );
    ex_we    = 1;
    ex_waddr = a;
    ex_wdata = d;
    ex_late  = late;
    ex_flush = fl;
  endtask

  task automatic idle_ex();
    ex_we    = 0;
    ex_late  = 0;
    ex_flush = 0;
  endtask

  task automatic rd(input int k, input logic [AW-1:0] a);
    re[k] = 1'b1;
    raddr[k*AW +: AW] = a;
  endtask

  function automatic logic [W-1:0] port(input int k);
    return rdata[k*W +: W];
  endfunction

  logic [W-1:0] ori [4];

  initial begin
    model_reset();
    ori[0] = 32'h0000_1100;
    ori[1] = 32'h0000_1120;
    ori[2] = 32'h0000_5520;
    ori[3] = 32'h0000_5564;

    ex(5'd1, 32'h5, 0, 0);
    rd(0, 5'd1);
    rd(1, 5'd1);
    look();
    chk("reset_rdata0", port(0), 32'h0);
    chk("reset_rdata1", port(1), 32'h0);
    chk("reset_hazard", W'(hazard), 32'h0);
    tick();
    idle_ex();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      ex(5'd5, ori[i], 0, 0);
      rd(0, 5'd5);
      rd(1, 5'd0);
      look();
      chk($sformatf("ori_fwd%0d", i), port(0), ori[i]);
      chk($sformatf("ori_hz%0d", i), W'(hazard), 32'h0);
      tick();
    end
    idle_ex();
    repeat (S) tick();
    look();
    chk("ori_drain_rd", port(0), 32'h5564);
    chk("ori_drain_reg", dut.regs[5], 32'h5564);

    ex(5'd3, 32'h999, 1, 0);
    rd(0, 5'd3);
    look();
    chk("lu_t0_hz", W'(hazard), 32'h1);
    tick();
    idle_ex();
    mem_fill_data = 32'hDEAD_BEEF;
    look();
    chk("lu_t1_hz", W'(hazard), 32'h1);
    chk("lu_t1_rd", port(0), 32'h0);
    tick();
    mem_fill_data = 32'h0;
    look();
    chk("lu_fill_rd", port(0), 32'hDEAD_BEEF);
    chk("lu_fill_hz", W'(hazard), 32'h0);
    tick();

    ex(5'd4, 32'h11, 0, 0);
    rd(0, 5'd4);
    tick();
    ex(5'd4, 32'h0, 1, 0);
    tick();
    idle_ex();
    mem_fill_data = 32'h77;
    look();
    chk("prio_hz", W'(hazard), 32'h1);
    chk("prio_rd", port(0), 32'h0);
    tick();
    mem_fill_data = 32'h0;
    look();
    chk("prio_fill_rd", port(0), 32'h77);
    tick();

    ex(5'd0, 32'hFFFF, 0, 0);
    rd(0, 5'd0);
    rd(1, 5'd6);
    look();
    chk("r0_rd", port(0), 32'h0);
    chk("r6_rd", port(1), 32'h0);
    tick();
    ex(5'd6, 32'h22, 0, 1);
    look();
    chk("flush_rd", port(1), 32'h0);
    tick();
    idle_ex();
    repeat (S) tick();
    look();
    chk("flush_drain_rd", port(1), 32'h0);
    chk("r0_reg", dut.regs[0], 32'h0);
    chk("r6_reg", dut.regs[6], 32'h0);

    ex(5'd7, 32'h5, 0, 0);
    rd(0, 5'd7);
    tick();
    idle_ex();
    repeat (S) tick();
    look();
    chk("hold_pre_reg", dut.regs[7], 32'h5);
    ex(5'd7, 32'h33, 0, 0);
    tick();
    idle_ex();
    tick();
    hold = 1'b1;
    ex(5'd9, 32'hAA, 0, 0);
    for (int i = 0; i < 3; i++) begin
      look();
      chk($sformatf("hold_rd%0d", i), port(0), 32'h33);
      chk($sformatf("hold_reg%0d", i), dut.regs[7], 32'h5);
      tick();
    end
    hold = 1'b0;
    idle_ex();
    look();
    chk("unhold_pre_reg", dut.regs[7], 32'h5);
    tick();
    look();
    chk("unhold_reg", dut.regs[7], 32'h33);
    rd(1, 5'd9);
    repeat (S) tick();
    look();
    chk("hold_nocap_r9", port(1), 32'h0);

    ex(5'd8, 32'h88, 0, 0);
    rd(0, 5'd8);
    rd(1, 5'd8);
    tick();
    idle_ex();
    look();
    chk("rst_pre_rd", port(0), 32'h88);
    rst = 1'b0;
    #1;
    chk("rst_mid_rd0", port(0), 32'h0);
    chk("rst_mid_rd1", port(1), 32'h0);
    chk("rst_mid_hz", W'(hazard), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    repeat (S + 1) tick();
    look();
    chk("rst_post_rd", port(0), 32'h0);
    chk("rst_post_r8", dut.regs[8], 32'h0);
    chk("rst_post_r5", dut.regs[5], 32'h0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
